// File: rtl/uart_cfg_pkg.sv
// Shared types and helpers for the configurable UART core.
//   parity_e    : parity mode encoding (none / even / odd)
//   tx_state_e  : transmitter FSM states
//   rx_state_e  : receiver FSM states
//   calc_div    : clocks per bit from clock frequency and baud rate
//   parity_bit  : parity bit for a zero-extended payload
package uart_cfg_pkg;

   localparam int unsigned MaxDataBits = 9;

   typedef enum logic [1:0] {
      ParNone = 2'd0,
      ParEven = 2'd1,
      ParOdd  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TxIdle,
      TxStart,
      TxData,
      TxParity,
      TxStop
   } tx_state_e;

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
      RxParity,
      RxStop
   } rx_state_e;

   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / baud;
   endfunction

   // Even parity is the XOR of the payload; odd parity is its inverse.
   function automatic logic parity_bit(input logic [MaxDataBits-1:0] data,
                                       input parity_e                mode);
      return (^data) ^ (mode == ParOdd);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the transmitter and receiver.
//   clk, rst_n : clock and asynchronous active-low reset
//   run        : count while high; counter held at 0 while low
//   restart    : reload the counter to 0 on the next edge
//   tc_full    : high on the last clock of a DIV-clock period
//   tc_half    : high on clock DIV/2 of a period (start-bit midpoint)
module uart_bit_timer #(
   parameter int unsigned DIV = 104
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic restart,
   output logic tc_full,
   output logic tc_half
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DIV - 1);
   localparam logic [CntW-1:0] HalfCnt = CntW'((DIV / 2 > 0) ? (DIV / 2 - 1) : 0);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc_full = run && (cnt_q == FullCnt);
   assign tc_half = run && (cnt_q == HalfCnt);

   // Wraps on its own at the end of each period so back-to-back bits need no reload.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!run || restart || tc_full) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cfg_core.sv
// Configurable full-duplex UART: independent transmitter and receiver.
//   clk, rst_n : system clock and asynchronous active-low reset
//   rx         : serial input (asynchronous, idle high)
//   dintx      : transmit payload, captured when newd is accepted
//   newd       : one-cycle transmit request
//   tx         : serial output (idle high)
//   busytx     : transmitter busy from accept until frame end
//   donetx     : pulse on the last clock of the last stop bit
//   doutrx     : last received payload
//   donerx     : pulse when a received frame completes
//   perr, ferr : parity / framing error of the last received frame
module uart_cfg_core
   import uart_cfg_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 1000000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic [DATA_BITS-1:0] dintx,
   input  logic                 newd,
   output logic                 tx,
   output logic                 busytx,
   output logic                 donetx,
   output logic [DATA_BITS-1:0] doutrx,
   output logic                 donerx,
   output logic                 perr,
   output logic                 ferr
);

   localparam int unsigned Div      = calc_div(CLK_FREQ, BAUD);
   localparam parity_e     ParMode  = parity_e'(PARITY[1:0]);
   localparam logic [3:0]  LastData = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LastStop = 4'(STOP_BITS - 1);

   // ---------------------------------------------------------------- transmitter
   tx_state_e              tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0]   tx_shreg_q, tx_shreg_d;
   logic [3:0]             tx_bit_q, tx_bit_d;
   logic                   tx_par_q, tx_par_d;
   logic                   tx_q, tx_d;
   logic                   tx_restart, tx_tc, tx_half_unused, accept;
   logic [MaxDataBits-1:0] dintx_ext;

   always_comb begin
      dintx_ext                = '0;
      dintx_ext[DATA_BITS-1:0] = dintx;
   end

   uart_bit_timer #(
      .DIV (Div)
   ) u_tx_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (tx_state_q != TxIdle),
      .restart (tx_restart),
      .tc_full (tx_tc),
      .tc_half (tx_half_unused)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shreg_d = tx_shreg_q;
      tx_bit_d   = tx_bit_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      tx_restart = 1'b0;
      donetx     = 1'b0;
      accept     = 1'b0;
      case (tx_state_q)
         TxIdle: begin
            tx_d   = 1'b1;
            accept = newd;
         end
         TxStart: begin
            if (tx_tc) begin
               tx_state_d = TxData;
               tx_d       = tx_shreg_q[0];
               tx_bit_d   = '0;
            end
         end
         TxData: begin
            if (tx_tc) begin
               if (tx_bit_q == LastData) begin
                  tx_bit_d = '0;
                  if (ParMode != ParNone) begin
                     tx_state_d = TxParity;
                     tx_d       = tx_par_q;
                  end else begin
                     tx_state_d = TxStop;
                     tx_d       = 1'b1;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + 4'd1;
                  tx_shreg_d = tx_shreg_q >> 1;
                  tx_d       = tx_shreg_q[1];
               end
            end
         end
         TxParity: begin
            if (tx_tc) begin
               tx_state_d = TxStop;
               tx_d       = 1'b1;
            end
         end
         TxStop: begin
            if (tx_tc) begin
               if (tx_bit_q == LastStop) begin
                  // A request on the final stop clock chains straight into the next frame.
                  donetx = 1'b1;
                  accept = newd;
                  if (!newd) begin
                     tx_state_d = TxIdle;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end
         end
         default: tx_state_d = TxIdle;
      endcase
      if (accept) begin
         tx_state_d = TxStart;
         tx_shreg_d = dintx;
         tx_par_d   = parity_bit(dintx_ext, ParMode);
         tx_d       = 1'b0;
         tx_bit_d   = '0;
         tx_restart = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TxIdle;
         tx_shreg_q <= '0;
         tx_bit_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shreg_q <= tx_shreg_d;
         tx_bit_q   <= tx_bit_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
      end
   end

   assign tx     = tx_q;
   assign busytx = (tx_state_q != TxIdle);

   // ------------------------------------------------------------------- receiver
   rx_state_e              rx_state_q, rx_state_d;
   logic [DATA_BITS-1:0]   rx_shreg_q, rx_shreg_d;
   logic [3:0]             rx_bit_q, rx_bit_d;
   logic                   rx_par_q, rx_par_d;
   logic [DATA_BITS-1:0]   doutrx_q, doutrx_d;
   logic                   donerx_q, donerx_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   sync1_q, sync2_q, rx_prev_q;
   logic                   rx_s, rx_fall;
   logic                   rx_restart, rx_tc, rx_half;
   logic [MaxDataBits-1:0] rx_shreg_ext;

   assign rx_s = sync2_q;
   // Start detection is edge based: after a frame ending with rx held low (break),
   // no new start is seen until the line has returned high.
   assign rx_fall = rx_prev_q && !rx_s;

   always_comb begin
      rx_shreg_ext                = '0;
      rx_shreg_ext[DATA_BITS-1:0] = rx_shreg_q;
   end

   uart_bit_timer #(
      .DIV (Div)
   ) u_rx_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (rx_state_q != RxIdle),
      .restart (rx_restart),
      .tc_full (rx_tc),
      .tc_half (rx_half)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_shreg_d = rx_shreg_q;
      rx_bit_d   = rx_bit_q;
      rx_par_d   = rx_par_q;
      doutrx_d   = doutrx_q;
      donerx_d   = 1'b0;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      rx_restart = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            if (rx_fall) begin
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_half) begin
               if (rx_s) begin
                  rx_state_d = RxIdle;
               end else begin
                  // Realign so later samples land DIV clocks apart from this midpoint.
                  rx_state_d = RxData;
                  rx_bit_d   = '0;
                  rx_restart = 1'b1;
               end
            end
         end
         RxData: begin
            if (rx_tc) begin
               rx_shreg_d = {rx_s, rx_shreg_q[DATA_BITS-1:1]};
               if (rx_bit_q == LastData) begin
                  rx_state_d = (ParMode != ParNone) ? RxParity : RxStop;
               end else begin
                  rx_bit_d = rx_bit_q + 4'd1;
               end
            end
         end
         RxParity: begin
            if (rx_tc) begin
               rx_par_d   = rx_s;
               rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_tc) begin
               donerx_d   = 1'b1;
               doutrx_d   = rx_shreg_q;
               ferr_d     = !rx_s;
               perr_d     = (ParMode != ParNone) &&
                            (rx_par_q != parity_bit(rx_shreg_ext, ParMode));
               rx_state_d = RxIdle;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_shreg_q <= '0;
         rx_bit_q   <= '0;
         rx_par_q   <= 1'b0;
         doutrx_q   <= '0;
         donerx_q   <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sync1_q    <= rx;
         sync2_q    <= sync1_q;
         rx_prev_q  <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_shreg_q <= rx_shreg_d;
         rx_bit_q   <= rx_bit_d;
         rx_par_q   <= rx_par_d;
         doutrx_q   <= doutrx_d;
         donerx_q   <= donerx_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
      end
   end

   assign doutrx = doutrx_q;
   assign donerx = donerx_q;
   assign perr   = perr_q;
   assign ferr   = ferr_q;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed bench for uart_cfg_core with a receive scoreboard per instance.
//   dut_a : default parameters, rx selectable between loopback and bench drive
//   dut_b : DATA_BITS=7, even parity, loopback
//   dut_c : odd parity, rx driven by the bench
module tb_uart_cfg_core;

   localparam int Div = 1000000 / 9600;

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       loop_a, rx_a_drv, rx_a, newd_a;
   logic [7:0] dintx_a, doutrx_a;
   logic       tx_a, busytx_a, donetx_a, donerx_a, perr_a, ferr_a;

   logic       rx_b, newd_b;
   logic [6:0] dintx_b, doutrx_b;
   logic       tx_b, busytx_b, donetx_b, donerx_b, perr_b, ferr_b;

   logic       rx_c_drv, newd_c;
   logic [7:0] dintx_c, doutrx_c;
   logic       tx_c, busytx_c, donetx_c, donerx_c, perr_c, ferr_c;

   assign rx_a = loop_a ? tx_a : rx_a_drv;
   assign rx_b = tx_b;

   uart_cfg_core dut_a (
      .clk (clk), .rst_n (rst_n), .rx (rx_a), .dintx (dintx_a), .newd (newd_a),
      .tx (tx_a), .busytx (busytx_a), .donetx (donetx_a), .doutrx (doutrx_a),
      .donerx (donerx_a), .perr (perr_a), .ferr (ferr_a)
   );

   uart_cfg_core #(.DATA_BITS (7), .PARITY (1)) dut_b (
      .clk (clk), .rst_n (rst_n), .rx (rx_b), .dintx (dintx_b), .newd (newd_b),
      .tx (tx_b), .busytx (busytx_b), .donetx (donetx_b), .doutrx (doutrx_b),
      .donerx (donerx_b), .perr (perr_b), .ferr (ferr_b)
   );

   uart_cfg_core #(.PARITY (2)) dut_c (
      .clk (clk), .rst_n (rst_n), .rx (rx_c_drv), .dintx (dintx_c), .newd (newd_c),
      .tx (tx_c), .busytx (busytx_c), .donetx (donetx_c), .doutrx (doutrx_c),
      .donerx (donerx_c), .perr (perr_c), .ferr (ferr_c)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_rx_a  = 0;
   int   n_tx_a  = 0;
   int   t_rx_a  = 0;
   int   t_tx_a  = 0;
   exp_t q_a[$], q_b[$], q_c[$];
   exp_t e_a, e_b, e_c;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic unexpected(input string tag);
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed donerx with empty scoreboard, expected none", tag);
   endtask

   function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
      exp_t e;
      e.data = d;
      e.perr = p;
      e.ferr = f;
      return e;
   endfunction

   // ---------------------------------------------------------------- monitors
   always @(negedge clk) begin
      if (rst_n && donetx_a) begin
         n_tx_a++;
         t_tx_a = cyc;
      end
      if (rst_n && donerx_a) begin
         n_rx_a++;
         t_rx_a = cyc;
         if (q_a.size() == 0) begin
            unexpected("a_unexpected_donerx");
         end else begin
            e_a = q_a.pop_front();
            chk("a_doutrx", doutrx_a, e_a.data);
            chk("a_perr", perr_a, e_a.perr);
            chk("a_ferr", ferr_a, e_a.ferr);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && donerx_b) begin
         if (q_b.size() == 0) begin
            unexpected("b_unexpected_donerx");
         end else begin
            e_b = q_b.pop_front();
            chk("b_doutrx", doutrx_b, e_b.data);
            chk("b_perr", perr_b, e_b.perr);
            chk("b_ferr", ferr_b, e_b.ferr);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && donerx_c) begin
         if (q_c.size() == 0) begin
            unexpected("c_unexpected_donerx");
         end else begin
            e_c = q_c.pop_front();
            chk("c_doutrx", doutrx_c, e_c.data);
            chk("c_perr", perr_c, e_c.perr);
            chk("c_ferr", ferr_c, e_c.ferr);
         end
      end
   end

   // ------------------------------------------------------------------ helpers
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int qsize(input int sel);
      case (sel)
         0:       return q_a.size();
         1:       return q_b.size();
         default: return q_c.size();
      endcase
   endfunction

   task automatic wait_q_empty(input int sel, input int budget, input string tag);
      int k = 0;
      while (qsize(sel) != 0 && k < budget) begin
         k++;
         tick(1);
      end
      chk(tag, qsize(sel), 0);
   endtask

   task automatic wait_donetx_a(input int base, input int budget, input string tag);
      int k = 0;
      while (n_tx_a == base && k < budget) begin
         k++;
         tick(1);
      end
      chk(tag, n_tx_a - base, 1);
   endtask

   task automatic set_rx(input int sel, input logic v);
      if (sel == 0) rx_a_drv = v;
      else          rx_c_drv = v;
   endtask

   // Leaves the line at the stop-bit level; the caller decides what follows.
   task automatic drive_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic pbit, input logic stopbit);
      set_rx(sel, 1'b0);
      tick(Div);
      for (int i = 0; i < nbits; i++) begin
         set_rx(sel, data[i]);
         tick(Div);
      end
      if (has_par) begin
         set_rx(sel, pbit);
         tick(Div);
      end
      set_rx(sel, stopbit);
      tick(Div);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #600000;
      $display("FAIL watchdog: observed no end of sequence, expected finish before timeout");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------ stimulus
   initial begin
      int         low;
      int         base_rx;
      int         base_tx;
      int         gap;
      logic [7:0] d;
      logic       pb;

      rst_n    = 1'b0;
      loop_a   = 1'b1;
      rx_a_drv = 1'b1;
      newd_a   = 1'b0;
      dintx_a  = '0;
      newd_b   = 1'b0;
      dintx_b  = '0;
      newd_c   = 1'b0;
      dintx_c  = '0;
      rx_c_drv = 1'b1;
      tick(3);

      chk("rst_tx", tx_a, 1);
      chk("rst_busytx", busytx_a, 0);
      chk("rst_donetx", donetx_a, 0);
      chk("rst_doutrx", doutrx_a, 0);
      chk("rst_donerx", donerx_a, 0);
      chk("rst_perr", perr_a, 0);
      chk("rst_ferr", ferr_a, 0);
      chk("rst_tx_b", tx_b, 1);

      rst_n = 1'b1;
      tick(5);

      // Loopback 0xA5 on default parameters.
      q_a.push_back(mk(9'h0A5, 1'b0, 1'b0));
      base_tx = n_tx_a;
      dintx_a = 8'hA5;
      newd_a  = 1'b1;
      tick(1);
      newd_a  = 1'b0;
      chk("a_accept_tx_low", tx_a, 0);
      chk("a_accept_busytx", busytx_a, 1);
      low = 0;
      while (tx_a == 1'b0 && low < 500) begin
         low++;
         tick(1);
      end
      chk("a_start_bit_clocks", low, Div);
      wait_donetx_a(base_tx, 2000, "a_donetx_seen");
      tick(1);
      chk("a_busytx_after_done", busytx_a, 0);
      // donerx is raised from the stop-bit midpoint, so it leads donetx by about
      // half a bit less the synchroniser delay.
      gap = t_tx_a - t_rx_a;
      chk("a_done_gap_ok", (gap >= 0) && (gap <= Div / 2 + 3), 1);
      wait_q_empty(0, 200, "a_loop_a5_received");

      // 7 data bits, even parity, 0x55: four ones so the parity bit is 0.
      d  = 8'h55;
      pb = ^d[6:0];
      q_b.push_back(mk(9'h055, 1'b0, 1'b0));
      dintx_b = 7'h55;
      newd_b  = 1'b1;
      tick(1);
      newd_b  = 1'b0;
      tick(8 * Div + Div / 2);
      chk("b_parity_bit", tx_b, pb);
      wait_q_empty(1, 2000, "b_loop_55_received");

      // Odd parity, bench-driven 0x3C with the parity bit inverted.
      d  = 8'h3C;
      pb = ~(^d);
      q_c.push_back(mk(9'h03C, 1'b1, 1'b0));
      drive_frame(1, {1'b0, d}, 8, 1'b1, ~pb, 1'b1);
      rx_c_drv = 1'b1;
      tick(Div);
      wait_q_empty(2, 200, "c_bad_parity_received");
      chk("c_perr_held", perr_c, 1);
      d  = 8'h3D;
      pb = ~(^d);
      q_c.push_back(mk(9'h03D, 1'b0, 1'b0));
      drive_frame(1, {1'b0, d}, 8, 1'b1, pb, 1'b1);
      rx_c_drv = 1'b1;
      tick(Div);
      wait_q_empty(2, 200, "c_good_parity_received");

      // Framing error followed by a held-low line.
      loop_a = 1'b0;
      tick(Div);
      base_rx = n_rx_a;
      q_a.push_back(mk(9'h081, 1'b0, 1'b1));
      drive_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b0);
      tick(5 * Div);
      chk("a_break_one_donerx", n_rx_a - base_rx, 1);
      chk("a_ferr_held", ferr_a, 1);
      rx_a_drv = 1'b1;
      tick(2 * Div);
      chk("a_break_no_new_frame", n_rx_a - base_rx, 1);
      wait_q_empty(0, 10, "a_break_frame_received");

      // Short low glitch must not produce a frame; a real frame afterwards must.
      base_rx  = n_rx_a;
      rx_a_drv = 1'b0;
      tick(20);
      rx_a_drv = 1'b1;
      tick(2 * Div);
      chk("a_glitch_no_donerx", n_rx_a - base_rx, 0);
      q_a.push_back(mk(9'h012, 1'b0, 1'b0));
      drive_frame(0, 9'h012, 8, 1'b0, 1'b0, 1'b1);
      rx_a_drv = 1'b1;
      tick(Div);
      wait_q_empty(0, 200, "a_after_glitch_received");
      chk("a_after_glitch_count", n_rx_a - base_rx, 1);

      // Second request while busy is dropped.
      loop_a = 1'b1;
      tick(Div);
      base_tx = n_tx_a;
      base_rx = n_rx_a;
      q_a.push_back(mk(9'h011, 1'b0, 1'b0));
      dintx_a = 8'h11;
      newd_a  = 1'b1;
      tick(1);
      newd_a  = 1'b0;
      tick(49);
      dintx_a = 8'h22;
      newd_a  = 1'b1;
      tick(1);
      newd_a  = 1'b0;
      dintx_a = 8'h00;
      wait_donetx_a(base_tx, 2000, "a_first_frame_done");
      tick(2 * Div);
      chk("a_ignored_newd_one_txframe", n_tx_a - base_tx, 1);
      chk("a_ignored_newd_idle", busytx_a, 0);
      wait_q_empty(0, 10, "a_ignored_newd_received");
      chk("a_ignored_newd_one_rxframe", n_rx_a - base_rx, 1);

      // Reset in the middle of data bit 4 of 0x22 (a zero bit).
      base_tx = n_tx_a;
      base_rx = n_rx_a;
      d       = 8'h22;
      dintx_a = d;
      newd_a  = 1'b1;
      tick(1);
      newd_a  = 1'b0;
      tick(5 * Div + Div / 2);
      chk("a_pre_reset_tx", tx_a, d[4]);
      chk("a_pre_reset_busytx", busytx_a, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("a_reset_tx", tx_a, 1);
      chk("a_reset_busytx", busytx_a, 0);
      chk("a_reset_donetx", donetx_a, 0);
      tick(3);
      rst_n = 1'b1;
      tick(3 * Div);
      chk("a_post_reset_no_donetx", n_tx_a - base_tx, 0);
      chk("a_post_reset_no_donerx", n_rx_a - base_rx, 0);
      chk("a_post_reset_tx_idle", tx_a, 1);

      // First request after reset runs a complete fresh frame.
      q_a.push_back(mk(9'h05A, 1'b0, 1'b0));
      dintx_a = 8'h5A;
      newd_a  = 1'b1;
      tick(1);
      newd_a  = 1'b0;
      chk("a_post_reset_accept_tx", tx_a, 0);
      chk("a_post_reset_accept_busy", busytx_a, 1);
      wait_donetx_a(base_tx, 2000, "a_post_reset_donetx");
      wait_q_empty(0, 200, "a_post_reset_received");

      tick(10);
      chk("all_scoreboards_empty", q_a.size() + q_b.size() + q_c.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
